// File: rtl/counter_pkg.sv
// Shared definitions for the command-driven counter sequencer:
// opcodes, FSM state encoding and default datapath width.
package counter_pkg;

  localparam int DEFAULT_WIDTH = 8;

  localparam logic [1:0] OP_LOAD     = 2'b00;
  localparam logic [1:0] OP_RUN_UP   = 2'b01;
  localparam logic [1:0] OP_RUN_DOWN = 2'b10;
  localparam logic [1:0] OP_STOP     = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_RUN_UP   = 2'b01,
    ST_RUN_DOWN = 2'b10,
    ST_DONE     = 2'b11
  } state_t;

endpackage

// File: rtl/counter_ctrl_if.sv
// Command handshake and status bus between a host and counter_ctrl.
// The host drives the command fields; the controller drives everything else.
interface counter_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_arg;
  logic [WIDTH-1:0] out_data;
  logic             busy;
  logic             done;
  logic             wrap;
  logic             cmd_err;

  modport master (
    output cmd_valid, cmd_op, cmd_arg,
    input  cmd_ready, out_data, busy, done, wrap, cmd_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_arg,
    output cmd_ready, out_data, busy, done, wrap, cmd_err
  );
endinterface

// File: rtl/counter_core.sv
// WIDTH-bit counter register with load/inc/dec enables and a registered
// wrap flag that is high for exactly the cycle following a wrapping step.
module counter_core #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             inc,
  input  logic             dec,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] value,
  output logic             wrap
);

  logic [WIDTH-1:0] value_reg;
  logic             wrap_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      value_reg <= '0;
      wrap_reg  <= 1'b0;
    end else begin
      wrap_reg <= 1'b0;
      // load has priority; inc and dec are mutually exclusive by construction
      if (load) begin
        value_reg <= load_value;
      end else if (inc) begin
        value_reg <= value_reg + WIDTH'(1);
        wrap_reg  <= (value_reg == {WIDTH{1'b1}});
      end else if (dec) begin
        value_reg <= value_reg - WIDTH'(1);
        wrap_reg  <= (value_reg == '0);
      end
    end
  end

  assign value = value_reg;
  assign wrap  = wrap_reg;

endmodule

// File: rtl/counter_ctrl.sv
// Sequencer FSM: accepts LOAD/RUN/STOP commands and steps counter_core
// for a commanded number of cycles, emitting done/wrap/cmd_err pulses.
module counter_ctrl
  import counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic           clk,
  input  logic           reset,
  counter_ctrl_if.slave  bus
);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] remaining_reg, remaining_next;
  logic             busy_reg, done_reg, cmd_err_reg, cmd_err_next;
  logic             core_load, core_inc, core_dec;
  logic [WIDTH-1:0] core_value;
  logic             core_wrap;
  logic             accept, stop_req, last_step;

  assign bus.cmd_ready = (state_reg != ST_DONE);
  assign accept        = bus.cmd_valid && bus.cmd_ready;
  assign stop_req      = accept && (bus.cmd_op == OP_STOP);
  assign last_step     = (remaining_reg == WIDTH'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      remaining_reg <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      cmd_err_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      remaining_reg <= remaining_next;
      busy_reg      <= (state_next == ST_RUN_UP) || (state_next == ST_RUN_DOWN);
      done_reg      <= (state_next == ST_DONE);
      cmd_err_reg   <= cmd_err_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    remaining_next = remaining_reg;
    core_load      = 1'b0;
    core_inc       = 1'b0;
    core_dec       = 1'b0;
    cmd_err_next   = 1'b0;

    unique case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          unique case (bus.cmd_op)
            OP_LOAD: core_load = 1'b1;
            OP_RUN_UP, OP_RUN_DOWN: begin
              if (bus.cmd_arg == '0) begin
                state_next = ST_DONE;
              end else begin
                remaining_next = bus.cmd_arg;
                state_next     = (bus.cmd_op == OP_RUN_UP) ? ST_RUN_UP : ST_RUN_DOWN;
              end
            end
            default: cmd_err_next = 1'b1;
          endcase
        end
      end

      ST_RUN_UP, ST_RUN_DOWN: begin
        // A STOP on the final step still takes that step; only one done results
        if (stop_req && !last_step) begin
          state_next = ST_DONE;
        end else begin
          core_inc       = (state_reg == ST_RUN_UP);
          core_dec       = (state_reg == ST_RUN_DOWN);
          remaining_next = remaining_reg - WIDTH'(1);
          if (last_step) state_next = ST_DONE;
        end
        if (accept && !stop_req) cmd_err_next = 1'b1;
      end

      default: begin
        state_next     = ST_IDLE;
        remaining_next = '0;
      end
    endcase
  end

  counter_core #(.WIDTH(WIDTH)) u_core (
    .clk        (clk),
    .reset      (reset),
    .load       (core_load),
    .inc        (core_inc),
    .dec        (core_dec),
    .load_value (bus.cmd_arg),
    .value      (core_value),
    .wrap       (core_wrap)
  );

  assign bus.out_data = core_value;
  assign bus.wrap     = core_wrap;
  assign bus.busy     = busy_reg;
  assign bus.done     = done_reg;
  assign bus.cmd_err  = cmd_err_reg;

endmodule

// File: tb/tb_counter_ctrl.sv
// Directed testbench for counter_ctrl with hand-computed expected values.
module tb_counter_ctrl;
  import counter_pkg::*;

  logic clk;
  logic reset;
  int   assert_count = 0;
  int   fail_count   = 0;

  counter_ctrl_if #(.WIDTH(8)) bus ();

  counter_ctrl #(.WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert_count++;
    if (obs !== exp) begin
      fail_count++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end else begin
      $display("ok   %s: %0d", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] op, input logic [7:0] arg);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_arg   = arg;
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  // Sample a full status snapshot against expected values
  task automatic expect_state(input string tag, input int data, input bit busy,
                              input bit done, input bit wrap, input bit err, input bit rdy);
    check_eq({tag, ".data"}, 32'(bus.out_data), 32'(data));
    check_eq({tag, ".busy"}, 32'(bus.busy), 32'(busy));
    check_eq({tag, ".done"}, 32'(bus.done), 32'(done));
    check_eq({tag, ".wrap"}, 32'(bus.wrap), 32'(wrap));
    check_eq({tag, ".err"},  32'(bus.cmd_err), 32'(err));
    check_eq({tag, ".rdy"},  32'(bus.cmd_ready), 32'(rdy));
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = OP_LOAD;
    bus.cmd_arg   = '0;
    reset         = 1'b1;
    tick();
    tick();
    expect_state("reset", 0, 0, 0, 0, 0, 1);
    reset = 1'b0;

    // LOAD 5, RUN_UP 3 -> 6,7,8 then done
    send(OP_LOAD, 8'd5);
    expect_state("load5", 5, 0, 0, 0, 0, 1);
    send(OP_RUN_UP, 8'd3);
    expect_state("up3.e0", 5, 1, 0, 0, 0, 1);
    tick(); expect_state("up3.e1", 6, 1, 0, 0, 0, 1);
    tick(); expect_state("up3.e2", 7, 1, 0, 0, 0, 1);
    tick(); expect_state("up3.e3", 8, 0, 1, 0, 0, 0);
    tick(); expect_state("up3.idle", 8, 0, 0, 0, 0, 1);

    // Wrap upward 255 -> 0
    send(OP_LOAD, 8'd254);
    send(OP_RUN_UP, 8'd3);
    tick(); expect_state("wu.e1", 255, 1, 0, 0, 0, 1);
    tick(); expect_state("wu.e2", 0, 1, 0, 1, 0, 1);
    tick(); expect_state("wu.e3", 1, 0, 1, 0, 0, 0);
    tick();

    // Wrap downward 0 -> 255
    send(OP_LOAD, 8'd1);
    send(OP_RUN_DOWN, 8'd2);
    tick(); expect_state("wd.e1", 0, 1, 0, 0, 0, 1);
    tick(); expect_state("wd.e2", 255, 0, 1, 1, 0, 0);
    tick(); expect_state("wd.idle", 255, 0, 0, 0, 0, 1);

    // RUN_UP with N=0: straight to DONE, no step, never busy
    send(OP_RUN_UP, 8'd0);
    expect_state("n0.e0", 255, 0, 1, 0, 0, 0);
    tick(); expect_state("n0.idle", 255, 0, 0, 0, 0, 1);

    // LOAD 10, RUN_UP 100, LOAD 77 mid-run dropped, STOP after 4 steps
    send(OP_LOAD, 8'd10);
    send(OP_RUN_UP, 8'd100);
    tick(); expect_state("stop.e1", 11, 1, 0, 0, 0, 1);
    tick(); expect_state("stop.e2", 12, 1, 0, 0, 0, 1);
    send(OP_LOAD, 8'd77);
    expect_state("stop.ld77", 13, 1, 0, 0, 1, 1);
    tick(); expect_state("stop.e4", 14, 1, 0, 0, 0, 1);
    send(OP_STOP, 8'd0);
    expect_state("stop.e5", 14, 0, 1, 0, 0, 0);
    tick(); expect_state("stop.idle", 14, 0, 0, 0, 0, 1);
    tick(); expect_state("stop.hold", 14, 0, 0, 0, 0, 1);

    // STOP coinciding with the final step: step taken, single done
    send(OP_RUN_UP, 8'd2);
    tick(); expect_state("fs.e1", 15, 1, 0, 0, 0, 1);
    send(OP_STOP, 8'd0);
    expect_state("fs.e2", 16, 0, 1, 0, 0, 0);
    tick(); expect_state("fs.idle", 16, 0, 0, 0, 0, 1);

    // Reset mid RUN_DOWN with a LOAD presented at the same time
    send(OP_LOAD, 8'd50);
    send(OP_RUN_DOWN, 8'd10);
    tick(); tick();
    check_eq("rd.pre", 32'(bus.out_data), 32'd48);
    reset         = 1'b1;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = OP_LOAD;
    bus.cmd_arg   = 8'd99;
    tick();
    expect_state("rst.mid", 0, 0, 0, 0, 0, 1);
    reset         = 1'b0;
    bus.cmd_valid = 1'b0;
    tick(); expect_state("rst.after", 0, 0, 0, 0, 0, 1);

    // STOP in IDLE: cmd_err only
    send(OP_STOP, 8'd0);
    expect_state("idlestop", 0, 0, 0, 0, 1, 1);
    tick(); expect_state("idlestop.clr", 0, 0, 0, 0, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule

// File: doc/counter_ctrl.md
# counter_ctrl

Command-driven sequencer for the 8-bit free-running counter datapath. It accepts load / run / stop commands over a valid-ready handshake and steps the counter up or down by a commanded number of clock cycles. It reports completion and wrap-around as single-cycle pulses. It sits between a host/test driver and the counter value bus `out_data`, replacing the unconditional count-every-clock behaviour with controlled runs.

## Interface
Parameters:
- `WIDTH`, 8: counter and argument width.

Ports:
- `clk`  in  1  single system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high; sampled on the rising edge of `clk`.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  controller can accept a command this cycle.
- `cmd_op`  in  2  opcode: 00 LOAD, 01 RUN_UP, 10 RUN_DOWN, 11 STOP.
- `cmd_arg`  in  WIDTH  LOAD value, or step count N for RUN_*; ignored for STOP.
- `out_data`  out  WIDTH  current counter value (registered).
- `busy`  out  1  high while in RUN_UP or RUN_DOWN state.
- `done`  out  1  one-cycle pulse: run finished or stopped.
- `wrap`  out  1  one-cycle pulse: the step just taken wrapped (max→0 up, 0→max down).
- `cmd_err`  out  1  one-cycle pulse: an accepted command was illegal in the current state and was dropped.

## Operation
- FSM states: IDLE, RUN_UP, RUN_DOWN, DONE. A 2^WIDTH-range `remaining` register holds the steps still to take.
- Handshake: a command transfers on an edge where `cmd_valid && cmd_ready`. `cmd_ready` is combinational and equals (state != DONE).
- IDLE:
  - LOAD: `out_data` <= `cmd_arg`. Stay IDLE. No `done`.
  - RUN_UP / RUN_DOWN with N>0: `remaining` <= N, go to the matching RUN state.
  - RUN_* with N=0: go straight to DONE.
  - STOP: no-op; assert `cmd_err`.
- RUN_UP / RUN_DOWN, no accepted STOP:
  - Each edge does `out_data` ±1 modulo 2^WIDTH and `remaining` −1.
  - The edge that makes `remaining` 0 moves the FSM to DONE.
  - `wrap` is registered alongside the wrapping step.
- RUN, accepted STOP: no step on that edge; go to DONE. A STOP that coincides with the final step still takes the step, goes to DONE, and produces one `done` pulse only.
- RUN, accepted LOAD / RUN_*: command is dropped, `cmd_err` pulses, and the run continues unaffected.
- DONE: lasts exactly one cycle with `done`=1, then returns to IDLE. Commands are not accepted.
- Arithmetic is unsigned, WIDTH bits, natural wrap; no saturation.

## Timing
- Reset values: `out_data`=0, state IDLE, `remaining`=0, `busy`=0, `done`=0, `wrap`=0, `cmd_err`=0. `cmd_ready` is therefore 1 the cycle after reset.
- Reset has priority over every command and over the run in progress. A reset mid-run returns to IDLE with `out_data`=0 and no `done` pulse.
- LOAD latency: the new value is visible 1 cycle after the handshake edge.
- RUN of N>0 accepted at edge E0:
  - Steps occur at E1..EN.
  - `busy` is high from after E0 through EN.
  - `done` is high for the cycle after EN.
  - `cmd_ready` is low during that cycle and returns high after EN+1.
- `done`, `wrap`, and `cmd_err` are registered Moore/pulse outputs and are never combinational from inputs.

## Structure
- Shared package `counter_pkg`: opcode localparams (OP_LOAD, OP_RUN_UP, OP_RUN_DOWN, OP_STOP), FSM state encoding, default WIDTH.
- Sub-module `counter_core`:
  - Contents: WIDTH-bit register with `load`, `inc`, and `dec` enables, plus a `wrap` flag output.
  - Enable rules: `load` beats `inc`/`dec`; `inc` and `dec` are never asserted together.
- `counter_ctrl` holds the FSM, the `remaining` counter, and the handshake/pulse logic.

## Test plan
- Reset, then LOAD 5, then RUN_UP N=3 → `out_data` 6,7,8 on consecutive cycles; `busy` high for 3 cycles; `done` pulses once with `out_data`=8; `cmd_ready` low that cycle only.
- LOAD 254, then RUN_UP N=3 → 255, 0, 1; `wrap` pulses exactly with the 255→0 step. LOAD 1, then RUN_DOWN N=2 → 0, 255; `wrap` on 0→255.
- RUN_UP N=0 from IDLE → no change to `out_data`; `done` the cycle after the handshake; `busy` never high.
- LOAD 10, then RUN_UP N=100, STOP accepted after 4 steps → `out_data` frozen at 14; `done` once. A LOAD 77 sent mid-run → `cmd_err` pulse; run unaffected.
- Assert `reset` during RUN_DOWN → next cycle `out_data`=0, `busy`=0, no `done`. A command presented with `reset` high is ignored. STOP in IDLE → `cmd_err` pulse only.
